layer_mem_arbiter: RTL and testbench

Shares the single layer-memory port (cwr/crd/csel/caddr_wr/caddr_rd/cdata_wr/cdata_rd) between NREQ engines: convolution writer, max-pool reader/writer and flatten/readback.
- Grants one memory beat per cycle using round-robin priority.
- Registers the winning beat onto the memory bus and returns read data with a per-requester valid strobe.
- Optionally lets one requester hold the port across a multi-beat burst.

---
 rtl/layer_mem_arbiter_if.sv | 44 ++++
 rtl/layer_mem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_layer_mem_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/layer_mem_arbiter_if.sv
// layer_mem_arbiter_if
// Bundles the requester-side handshake and the shared layer-memory bus
// seen by layer_mem_arbiter. The slave modport is the arbiter's view.
// The master modport is the view of the engines plus the memory.
interface layer_mem_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 12,
  parameter int DW   = 20
);
  // Requester side, one slice per engine
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ-1:0]    lock;
  logic [3*NREQ-1:0]  sel;
  logic [AW*NREQ-1:0] addr;
  logic [DW*NREQ-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;

  // Shared layer-memory port
  logic               cwr;
  logic               crd;
  logic [2:0]         csel;
  logic [AW-1:0]      caddr_wr;
  logic [AW-1:0]      caddr_rd;
  logic [DW-1:0]      cdata_wr;
  logic [DW-1:0]      cdata_rd;

  // Lock status
  logic               owner_busy;

  modport slave (
    input  req, we, lock, sel, addr, wdata, cdata_rd,
    output gnt, rvalid, rdata, cwr, crd, csel, caddr_wr, caddr_rd,
           cdata_wr, owner_busy
  );

  modport master (
    output req, we, lock, sel, addr, wdata, cdata_rd,
    input  gnt, rvalid, rdata, cwr, crd, csel, caddr_wr, caddr_rd,
           cdata_wr, owner_busy
  );
endinterface

// File: rtl/layer_mem_arbiter.sv
// layer_mem_arbiter
// Shares the single layer-memory port between NREQ engines. These are the
// convolution writer, the max-pool reader/writer and the flatten/readback.
//
// Behaviour:
//   - One beat is granted per cycle in round-robin order.
//   - The grant is combinational.
//   - The winning beat is registered onto the memory bus one cycle later.
//   - A read raises a one-hot rvalid in the same cycle as the read beat.
//   - rdata passes cdata_rd straight through.
//
// Build option ARB_LOCK_EN:
//   - When defined, the lock inputs are honoured.
//   - An IDLE/OWNED FSM then keeps the port for one owner across a burst.
//   - If the owner stays idle for LOCK_TIMEOUT cycles, it forfeits the lock.
//   - When undefined, every beat is re-arbitrated and owner_busy is tied 0.
module layer_mem_arbiter #(
  parameter int NREQ         = 3,
  parameter int AW           = 12,
  parameter int DW           = 20,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  layer_mem_arbiter_if.slave   mem_if
);

  localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE      = NREQ'(1);

  // Round-robin pointer
  logic [IW-1:0]   last_q, last_d;

  // Arbitration results
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] hiMask;
  logic [NREQ-1:0] hiReq;
  logic [NREQ-1:0] gntVec;
  logic            anyGnt;
  logic [IW-1:0]   winIdx;
  logic            winWe;
  logic            winLock;
  logic [2:0]      winSel;
  logic [AW-1:0]   winAddr;
  logic [DW-1:0]   winData;

  // Registered memory bus and read-valid strobe
  logic            cwr_q, cwr_d;
  logic            crd_q, crd_d;
  logic [2:0]      csel_q, csel_d;
  logic [AW-1:0]   caddrWr_q, caddrWr_d;
  logic [AW-1:0]   caddrRd_q, caddrRd_d;
  logic [DW-1:0]   cdataWr_q, cdataWr_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          state_q;
  logic [IW-1:0]   owner_q;
  logic [CW-1:0]   idleCnt_q;
  logic            busy_q;
  logic            timeoutHit;

  // The owner gives up the port on the cycle its idle run reaches the limit.
  // In OWNED, a cycle without a grant always means the owner was not requesting.
  assign timeoutHit = (state_q == OWNED) && !mem_if.req[owner_q] &&
                      (idleCnt_q == CW'(LOCK_TIMEOUT - 1));
`else
  logic            unusedLock;

  // The lock inputs and the timeout have no meaning without the lock FSM
  assign unusedLock = ^{mem_if.lock, 32'(LOCK_TIMEOUT)};
`endif

  // Pick the winner.
  // Requests above the pointer go first; otherwise the search wraps to the bottom.
  // The lowest set bit is isolated with x & -x.
  // While a lock is held, only the owner may compete.
  // No beat is accepted during reset.
  always_comb begin
    eligible = mem_if.req;
`ifdef ARB_LOCK_EN
    if (state_q == OWNED) eligible = mem_if.req & (ONE << owner_q);
`endif
    if (reset) eligible = '0;

    for (int i = 0; i < NREQ; i++) hiMask[i] = (IW'(i) > last_q);
    hiReq = eligible & hiMask;

    if (hiReq != '0) gntVec = hiReq & (~hiReq + ONE);
    else             gntVec = eligible & (~eligible + ONE);

    anyGnt  = (gntVec != '0);
    winIdx  = '0;
    winWe   = 1'b0;
    winLock = 1'b0;
    winSel  = '0;
    winAddr = '0;
    winData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gntVec[i]) begin
        winIdx  = IW'(i);
        winWe   = mem_if.we[i];
        winLock = mem_if.lock[i];
        winSel  = mem_if.sel[3*i +: 3];
        winAddr = mem_if.addr[AW*i +: AW];
        winData = mem_if.wdata[DW*i +: DW];
      end
    end
  end

  // Next bus contents.
  // Write and read beats drive disjoint address/data fields; the unused side stays 0.
  always_comb begin
    cwr_d     = anyGnt &&  winWe;
    crd_d     = anyGnt && !winWe;
    csel_d    = anyGnt ? winSel : 3'b000;
    caddrWr_d = cwr_d ? winAddr : '0;
    cdataWr_d = cwr_d ? winData : '0;
    caddrRd_d = crd_d ? winAddr : '0;
    rvalid_d  = crd_d ? gntVec  : '0;
  end

  // Next pointer.
  // It follows each grant; on a lock timeout it is parked on the owner,
  // so the owner drops to lowest priority.
  always_comb begin
    last_d = anyGnt ? winIdx : last_q;
`ifdef ARB_LOCK_EN
    if (timeoutHit) last_d = owner_q;
`endif
  end

  // Register the round-robin pointer and the memory bus
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q    <= LAST_RST;
      cwr_q     <= 1'b0;
      crd_q     <= 1'b0;
      csel_q    <= 3'b000;
      caddrWr_q <= '0;
      caddrRd_q <= '0;
      cdataWr_q <= '0;
      rvalid_q  <= '0;
    end else begin
      last_q    <= last_d;
      cwr_q     <= cwr_d;
      crd_q     <= crd_d;
      csel_q    <= csel_d;
      caddrWr_q <= caddrWr_d;
      caddrRd_q <= caddrRd_d;
      cdataWr_q <= cdataWr_d;
      rvalid_q  <= rvalid_d;
    end
  end

`ifdef ARB_LOCK_EN
  // Lock FSM.
  // A granted beat with lock set claims the port.
  // The owner's beat with lock clear, or an idle timeout, hands it back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      idleCnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyGnt && winLock) begin
            state_q   <= OWNED;
            owner_q   <= winIdx;
            idleCnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        OWNED: begin
          if (anyGnt) begin
            idleCnt_q <= '0;
            if (!winLock) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (timeoutHit) begin
            state_q   <= IDLE;
            idleCnt_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            idleCnt_q <= idleCnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_if.owner_busy = busy_q;
`else
  assign mem_if.owner_busy = 1'b0;
`endif

  assign mem_if.gnt      = gntVec;
  assign mem_if.rvalid   = rvalid_q;
  assign mem_if.rdata    = mem_if.cdata_rd;
  assign mem_if.cwr      = cwr_q;
  assign mem_if.crd      = crd_q;
  assign mem_if.csel     = csel_q;
  assign mem_if.caddr_wr = caddrWr_q;
  assign mem_if.caddr_rd = caddrRd_q;
  assign mem_if.cdata_wr = cdataWr_q;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// tb_layer_mem_arbiter
// Directed and randomized stimulus for layer_mem_arbiter.
// The behavioural model searches the requesters in plain round-robin order
// and tracks the lock owner and its idle count as integers.
// Lock scenarios run only when ARB_LOCK_EN is defined.
module tb_layer_mem_arbiter;
  localparam int NREQ         = 3;
  localparam int AW           = 12;
  localparam int DW           = 20;
  localparam int LOCK_TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  layer_mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) busIf ();

  layer_mem_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mem_if(busIf)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int              mLast;
  bit              mOwned;
  int              mOwner;
  int              mCnt;
  logic            expCwr;
  logic            expCrd;
  logic [2:0]      expSel;
  logic [AW-1:0]   expAddrWr;
  logic [AW-1:0]   expAddrRd;
  logic [DW-1:0]   expDataWr;
  logic [NREQ-1:0] expRvalid;

  // Compare one observed value with its expected value
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Put the model into its reset state
  task automatic modelReset();
    mLast     = NREQ - 1;
    mOwned    = 1'b0;
    mOwner    = 0;
    mCnt      = 0;
    expCwr    = 1'b0;
    expCrd    = 1'b0;
    expSel    = '0;
    expAddrWr = '0;
    expAddrRd = '0;
    expDataWr = '0;
    expRvalid = '0;
  endtask

  // Return the next requester after mLast, with wrap, that may be granted
  function automatic int modelWinner();
    int idx;
    if (reset) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (mLast + k) % NREQ;
      if (busIf.req[idx] && (!mOwned || idx == mOwner)) return idx;
    end
    return -1;
  endfunction

  // Apply one clock edge to the model
  task automatic modelAdvance(input int win);
    if (reset) begin
      modelReset();
      return;
    end
    if (win >= 0) begin
      expCwr    = busIf.we[win];
      expCrd    = !busIf.we[win];
      expSel    = busIf.sel[3*win +: 3];
      expAddrWr = busIf.we[win] ? busIf.addr[AW*win +: AW] : '0;
      expDataWr = busIf.we[win] ? busIf.wdata[DW*win +: DW] : '0;
      expAddrRd = busIf.we[win] ? '0 : busIf.addr[AW*win +: AW];
      expRvalid = '0;
      if (!busIf.we[win]) expRvalid[win] = 1'b1;
      mLast = win;
`ifdef ARB_LOCK_EN
      if (mOwned) begin
        mCnt = 0;
        if (!busIf.lock[win]) mOwned = 1'b0;
      end else if (busIf.lock[win]) begin
        mOwned = 1'b1;
        mOwner = win;
        mCnt   = 0;
      end
`endif
    end else begin
      expCwr    = 1'b0;
      expCrd    = 1'b0;
      expSel    = '0;
      expAddrWr = '0;
      expAddrRd = '0;
      expDataWr = '0;
      expRvalid = '0;
`ifdef ARB_LOCK_EN
      if (mOwned) begin
        mCnt++;
        if (mCnt == LOCK_TIMEOUT) begin
          mOwned = 1'b0;
          mLast  = mOwner;
          mCnt   = 0;
        end
      end
`endif
    end
  endtask

  // Drive one cycle of inputs; addresses and data are random
  task automatic applyStimulus(input logic [NREQ-1:0] reqV, input logic [NREQ-1:0] weV,
                               input logic [NREQ-1:0] lockV, input logic rst);
    reset          = rst;
    busIf.req      = reqV;
    busIf.we       = weV;
    busIf.lock     = lockV;
    busIf.sel      = (3*NREQ)'($urandom());
    busIf.addr     = (AW*NREQ)'({$urandom(), $urandom()});
    busIf.wdata    = (DW*NREQ)'({$urandom(), $urandom()});
    busIf.cdata_rd = DW'($urandom());
  endtask

  // Check the DUT at the falling edge, then let the rising edge happen
  task automatic runCycle();
    int win;
    logic [NREQ-1:0] expGnt;
    @(negedge clk);
    win    = modelWinner();
    expGnt = '0;
    if (win >= 0) expGnt[win] = 1'b1;
    checkOutput("gnt",        32'(busIf.gnt),        32'(expGnt));
    checkOutput("cwr",        32'(busIf.cwr),        32'(expCwr));
    checkOutput("crd",        32'(busIf.crd),        32'(expCrd));
    checkOutput("csel",       32'(busIf.csel),       32'(expSel));
    checkOutput("caddr_wr",   32'(busIf.caddr_wr),   32'(expAddrWr));
    checkOutput("caddr_rd",   32'(busIf.caddr_rd),   32'(expAddrRd));
    checkOutput("cdata_wr",   32'(busIf.cdata_wr),   32'(expDataWr));
    checkOutput("rvalid",     32'(busIf.rvalid),     32'(expRvalid));
    checkOutput("owner_busy", 32'(busIf.owner_busy), 32'(mOwned));
    if (expRvalid != '0) checkOutput("rdata", 32'(busIf.rdata), 32'(busIf.cdata_rd));
    modelAdvance(win);
    @(posedge clk);
    #1;
  endtask

  initial begin
    modelReset();

    // Reset for two cycles
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b1);
    runCycle();
    runCycle();

    // All three requesters write continuously; the grant rotates 001, 010, 100, 001
    for (int n = 0; n < 5; n++) begin
      applyStimulus(3'b111, 3'b111, 3'b000, 1'b0);
      runCycle();
    end

    // Requester 1 reads from 0A5 with sel 011; memory returns 12345
    applyStimulus(3'b010, 3'b000, 3'b000, 1'b0);
    busIf.addr[AW*1 +: AW] = 12'h0A5;
    busIf.sel[3*1 +: 3]    = 3'b011;
    runCycle();
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0);
    busIf.cdata_rd = 20'h12345;
    runCycle();

    // Bus idles for five cycles without requests
    for (int n = 0; n < 5; n++) begin
      applyStimulus(3'b000, 3'b000, 3'b000, 1'b0);
      runCycle();
    end

    // Randomized traffic with occasional reset pulses
    for (int n = 0; n < 400; n++) begin
      applyStimulus(NREQ'($urandom()), NREQ'($urandom()),
                    ($urandom_range(0, 3) == 0) ? NREQ'($urandom()) : '0,
                    ($urandom_range(0, 49) == 0));
      runCycle();
    end

`ifdef ARB_LOCK_EN
    // Requester 0 bursts four writes with lock 1,1,1,0 while requester 2 waits
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b1);
    runCycle();
    applyStimulus(3'b101, 3'b101, 3'b001, 1'b0); runCycle();
    applyStimulus(3'b101, 3'b101, 3'b001, 1'b0); runCycle();
    applyStimulus(3'b101, 3'b101, 3'b001, 1'b0); runCycle();
    applyStimulus(3'b101, 3'b101, 3'b000, 1'b0); runCycle();
    applyStimulus(3'b100, 3'b100, 3'b000, 1'b0); runCycle();
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0); runCycle();

    // Requester 1 locks, then goes quiet while requester 0 waits for the timeout
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b1);
    runCycle();
    applyStimulus(3'b010, 3'b010, 3'b010, 1'b0);
    runCycle();
    for (int n = 0; n < LOCK_TIMEOUT + 3; n++) begin
      applyStimulus(3'b001, 3'b001, 3'b000, 1'b0);
      runCycle();
    end

    // Reset arrives while requester 2 holds a lock and requester 0 is pending
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b1);
    runCycle();
    applyStimulus(3'b100, 3'b100, 3'b100, 1'b0); runCycle();
    applyStimulus(3'b101, 3'b101, 3'b100, 1'b0); runCycle();
    applyStimulus(3'b101, 3'b101, 3'b100, 1'b0); runCycle();
    applyStimulus(3'b101, 3'b101, 3'b100, 1'b1); runCycle();
    applyStimulus(3'b001, 3'b001, 3'b000, 1'b0); runCycle();
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0); runCycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
